// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the byte producers / UART TX core and the arbiter.
// master: the arbiter side; slave: the producers and the UART TX core.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      req;
    logic [NREQ-1:0][7:0] req_data;
    logic [NREQ-1:0]      gnt;
    logic [NREQ-1:0]      sent;
    logic                 timeout_err;
    logic                 busy;
    logic                 tx_en;
    logic [7:0]           tx_data;
    logic                 tx_done;

    modport master (
        input  req, req_data, tx_done,
        output gnt, sent, timeout_err, busy, tx_en, tx_data
    );

    modport slave (
        output req, req_data, tx_done,
        input  gnt, sent, timeout_err, busy, tx_en, tx_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART TX core between NREQ byte sources, with a SEND watchdog.
// Optional UART_TX_ARB_URGENT_EN: requester 0 pre-empts the round-robin order in IDLE.
module uart_tx_arbiter #(
    parameter int NREQ        = 4,
    parameter int TIMEOUT_CYC = 400000,
    parameter int GAP_CYC     = 2
) (
    input logic              i_clk,
    input logic              i_rst,
    uart_tx_arbiter_if.master io_bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam int GW = $clog2(GAP_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_GAP} state_t;

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_win;
    logic [CW-1:0]   r_cnt;
    logic [GW-1:0]   r_gap;
    logic [NREQ-1:0] r_gnt;
    logic [NREQ-1:0] r_sent;
    logic            r_timeout;
    logic            r_busy;
    logic            r_tx_en;
    logic [7:0]      r_tx_data;

    logic            w_found;
    logic [PW-1:0]   w_win;
    logic [PW-1:0]   w_next_ptr;
    logic            w_urgent;
    int              w_idx;

    // Descending scan so the smallest offset from r_ptr is the last (winning) hit.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = 0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            w_idx = (int'(r_ptr) + off) % NREQ;
            if (io_bus.req[w_idx]) begin
                w_found = 1'b1;
                w_win   = PW'(w_idx);
            end
        end
        if (w_urgent) begin
            w_found = 1'b1;
            w_win   = '0;
        end
    end

`ifdef UART_TX_ARB_URGENT_EN
    assign w_urgent = io_bus.req[0];
`else
    assign w_urgent = 1'b0;
`endif

    assign w_next_ptr = (w_win == PW'(NREQ - 1)) ? '0 : w_win + PW'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_win     <= '0;
            r_cnt     <= '0;
            r_gap     <= '0;
            r_gnt     <= '0;
            r_sent    <= '0;
            r_timeout <= 1'b0;
            r_busy    <= 1'b0;
            r_tx_en   <= 1'b0;
            r_tx_data <= 8'h00;
        end else begin
            r_gnt     <= '0;
            r_sent    <= '0;
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Gnt is registered here so it is visible during the LOAD cycle.
                    if (w_found) begin
                        r_win        <= w_win;
                        r_tx_data    <= io_bus.req_data[w_win];
                        r_gnt[w_win] <= 1'b1;
                        if (!w_urgent)
                            r_ptr <= w_next_ptr;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_tx_en <= 1'b1;
                    r_cnt   <= '0;
                    r_state <= S_SEND;
                end
                S_SEND: begin
                    if (io_bus.tx_done) begin
                        r_sent[r_win] <= 1'b1;
                        r_tx_en       <= 1'b0;
                        r_gap         <= '0;
                        r_state       <= S_GAP;
                    end else if (r_cnt == CW'(TIMEOUT_CYC - 1)) begin
                        r_timeout <= 1'b1;
                        r_tx_en   <= 1'b0;
                        r_gap     <= '0;
                        r_state   <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_GAP: begin
                    if (r_gap == GW'(GAP_CYC - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_gap <= r_gap + GW'(1);
                    end
                end
                default: begin
                    r_tx_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.gnt         = r_gnt;
    assign io_bus.sent        = r_sent;
    assign io_bus.timeout_err = r_timeout;
    assign io_bus.busy        = r_busy;
    assign io_bus.tx_en       = r_tx_en;
    assign io_bus.tx_data     = r_tx_data;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: NREQ=4, short watchdog (TIMEOUT_CYC=40), GAP_CYC=2.
module tb_uart_tx_arbiter;
    localparam int NREQ = 4;
    localparam int TO   = 40;
    localparam int GAP  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    uart_tx_arbiter_if #(.NREQ(NREQ)) u_if ();

    uart_tx_arbiter #(
        .NREQ(NREQ), .TIMEOUT_CYC(TO), .GAP_CYC(GAP)
    ) u_dut (
        .i_clk (clk),
        .i_rst (rst),
        .io_bus(u_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) until a grant appears; gnt is sampled 1ns after each edge.
    task automatic wait_gnt(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            tick();
            if (u_if.gnt != '0) break;
        end
        if (i == bound) chk("gnt_wait_expired", 32'd0, 32'd1);
    endtask

    task automatic wait_idle(input int bound);
        int i;
        for (i = 0; i < bound; i++) begin
            if (!u_if.busy) break;
            tick();
        end
        if (i == bound) chk("idle_wait_expired", 32'd0, 32'd1);
    endtask

    // One complete transfer expected from requester idx, TxDone one cycle into SEND.
    task automatic serve(input int idx, input logic [7:0] data);
        wait_gnt(20);
        chk("rr_gnt", 32'(u_if.gnt), 32'(1 << idx));
        chk("rr_data", 32'(u_if.tx_data), 32'(data));
        tick();
        chk("rr_txen", 32'(u_if.tx_en), 32'd1);
        u_if.tx_done = 1'b1;
        tick();
        u_if.tx_done = 1'b0;
        chk("rr_sent", 32'(u_if.sent), 32'(1 << idx));
    endtask

    initial begin
        u_if.req      = '0;
        u_if.req_data = '0;
        u_if.tx_done  = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_gnt",  32'(u_if.gnt), 32'd0);
        chk("rst_sent", 32'(u_if.sent), 32'd0);
        chk("rst_to",   32'(u_if.timeout_err), 32'd0);
        chk("rst_busy", 32'(u_if.busy), 32'd0);
        chk("rst_txen", 32'(u_if.tx_en), 32'd0);
        chk("rst_data", 32'(u_if.tx_data), 32'h00);
        rst = 1'b0;
        tick();

        // Single byte from requester 2, TxDone 20 cycles after TxEn
        u_if.req         = 4'b0100;
        u_if.req_data[2] = 8'h55;
        tick();
        chk("t2_gnt",  32'(u_if.gnt), 32'b0100);
        chk("t2_data", 32'(u_if.tx_data), 32'h55);
        chk("t2_busy", 32'(u_if.busy), 32'd1);
        chk("t2_txen_load", 32'(u_if.tx_en), 32'd0);
        u_if.req = '0;
        tick();
        chk("t2_txen", 32'(u_if.tx_en), 32'd1);
        chk("t2_gnt_pulse", 32'(u_if.gnt), 32'd0);
        for (int i = 0; i < 19; i++) tick();
        chk("t2_txen_held", 32'(u_if.tx_en), 32'd1);
        chk("t2_data_held", 32'(u_if.tx_data), 32'h55);
        u_if.tx_done = 1'b1;
        tick();
        u_if.tx_done = 1'b0;
        chk("t2_sent", 32'(u_if.sent), 32'b0100);
        chk("t2_txen_off", 32'(u_if.tx_en), 32'd0);
        chk("t2_no_to", 32'(u_if.timeout_err), 32'd0);
        tick();
        chk("t2_gap_busy", 32'(u_if.busy), 32'd1);
        chk("t2_sent_pulse", 32'(u_if.sent), 32'd0);
        tick();
        chk("t2_idle", 32'(u_if.busy), 32'd0);

        // All four requesting, pointer from 0 after reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        u_if.req = 4'b1111;
        for (int k = 0; k < NREQ; k++) u_if.req_data[k] = 8'hA0 + 8'(k);
        serve(0, 8'hA0);
        serve(1, 8'hA1);
        serve(2, 8'hA2);
        serve(3, 8'hA3);
        serve(0, 8'hA0);
        u_if.req = '0;
        wait_idle(10);

        // Watchdog: requester 1, TxDone never arrives (ptr is 1 here)
        u_if.req = 4'b0010;
        wait_gnt(10);
        chk("t4_gnt", 32'(u_if.gnt), 32'b0010);
        u_if.req = '0;
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        chk("t4_txen_last", 32'(u_if.tx_en), 32'd1);
        chk("t4_to_early", 32'(u_if.timeout_err), 32'd0);
        tick();
        chk("t4_to", 32'(u_if.timeout_err), 32'd1);
        chk("t4_no_sent", 32'(u_if.sent), 32'd0);
        chk("t4_txen_off", 32'(u_if.tx_en), 32'd0);
        tick();
        chk("t4_to_pulse", 32'(u_if.timeout_err), 32'd0);
        tick();
        chk("t4_idle", 32'(u_if.busy), 32'd0);

        // TxDone on the timeout cycle wins; TxDone in GAP/IDLE ignored (ptr is 2, winner 0)
        u_if.req = 4'b0001;
        wait_gnt(10);
        chk("t5_gnt", 32'(u_if.gnt), 32'b0001);
        u_if.req = '0;
        tick();
        for (int i = 0; i < TO - 1; i++) tick();
        u_if.tx_done = 1'b1;
        tick();
        chk("t5_sent", 32'(u_if.sent), 32'b0001);
        chk("t5_no_to", 32'(u_if.timeout_err), 32'd0);
        tick();
        chk("t5_gap_sent", 32'(u_if.sent), 32'd0);
        chk("t5_gap_to", 32'(u_if.timeout_err), 32'd0);
        tick();
        chk("t5_idle", 32'(u_if.busy), 32'd0);
        tick();
        chk("t5_idle_sent", 32'(u_if.sent), 32'd0);
        chk("t5_idle_busy", 32'(u_if.busy), 32'd0);
        u_if.tx_done = 1'b0;

        // Move the pointer to 2 by serving requester 1 (ptr is 1 here)
        u_if.req = 4'b0010;
        u_if.req_data[1] = 8'h11;
        serve(1, 8'h11);
        u_if.req = '0;
        wait_idle(10);

        // Urgency check with ptr=2, Req=1101
        u_if.req = 4'b1101;
`ifdef UART_TX_ARB_URGENT_EN
        serve(0, 8'hA0);
`else
        serve(2, 8'hA2);
`endif
        u_if.req = '0;
        wait_idle(10);
        // Urgent win leaves ptr at 2; round-robin win of 2 moves it to 3
        u_if.req = 4'b1110;
`ifdef UART_TX_ARB_URGENT_EN
        serve(2, 8'hA2);
`else
        serve(3, 8'hA3);
`endif
        u_if.req = '0;
        wait_idle(10);

        // Reset held mid-SEND drops TxEn on that edge and suppresses Sent
        u_if.req = 4'b0100;
        wait_gnt(10);
        u_if.req = '0;
        tick();
        chk("t1_send", 32'(u_if.tx_en), 32'd1);
        rst = 1'b1;
        u_if.tx_done = 1'b1;
        tick();
        chk("t1_mid_txen", 32'(u_if.tx_en), 32'd0);
        chk("t1_mid_sent", 32'(u_if.sent), 32'd0);
        chk("t1_mid_busy", 32'(u_if.busy), 32'd0);
        chk("t1_mid_data", 32'(u_if.tx_data), 32'h00);
        rst = 1'b0;
        tick();
        u_if.tx_done = 1'b0;
        chk("t1_after_sent", 32'(u_if.sent), 32'd0);
        chk("t1_after_gnt", 32'(u_if.gnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
